// File: rtl/ofdm_frame_gen.sv
// OFDM transmit framer: preamble A, then for each IFFT symbol a cyclic prefix followed by the body.
// Define OFDM_FRAME_GEN_PINGPONG_EN for two symbol buffers and back-to-back symbols without LOAD gaps.
module ofdm_frame_gen #(
  parameter int unsigned DATA_SIZE = 16,
  parameter int unsigned FFT_SIZE  = 64,
  parameter int unsigned CP_LEN    = 16,
  parameter int unsigned N_SHORT   = 10
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_en,
  input  logic                 i_start,
  input  logic [7:0]           i_num_sym,
  input  logic                 i_valid,
  input  logic [DATA_SIZE-1:0] in_data_i,
  input  logic [DATA_SIZE-1:0] in_data_q,
  output logic                 o_ready,
  output logic                 o_valid,
  output logic [DATA_SIZE-1:0] o_data_i,
  output logic [DATA_SIZE-1:0] o_data_q,
  input  logic                 i_ready,
  input  logic                 i_cfg_we,
  input  logic [3:0]           i_cfg_addr,
  input  logic [DATA_SIZE-1:0] i_cfg_data_i,
  input  logic [DATA_SIZE-1:0] i_cfg_data_q,
  output logic                 o_busy,
  output logic                 o_frame_done
);

  localparam int unsigned PreLen = N_SHORT * 16;
  localparam int unsigned MaxCnt = (PreLen > FFT_SIZE) ? PreLen : FFT_SIZE;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);
  localparam int unsigned AddrW  = $clog2(FFT_SIZE);
  localparam int unsigned SW     = 2 * DATA_SIZE;

  localparam logic [CntW-1:0]  PreLenC   = CntW'(PreLen);
  localparam logic [CntW-1:0]  FftC      = CntW'(FFT_SIZE);
  localparam logic [CntW-1:0]  CpLastC   = CntW'(CP_LEN - 1);
  localparam logic [AddrW-1:0] CpBaseC   = AddrW'(FFT_SIZE - CP_LEN);
  localparam logic [AddrW-1:0] AddrLastC = AddrW'(FFT_SIZE - 1);

  typedef enum logic [2:0] {StIdle, StPreA, StLoad, StCp, StBody, StDone} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [7:0]           sym_left_q, sym_left_d;
  logic [7:0]           load_left_q, load_left_d;
  logic [AddrW-1:0]     wr_cnt_q, wr_cnt_d;
  logic                 wr_sel_q, wr_sel_d;
  logic                 rd_sel_q, rd_sel_d;
  logic [1:0]           full_q, full_d;
  logic                 out_valid_q, out_valid_d;
  logic [DATA_SIZE-1:0] out_di_q, out_di_d;
  logic [DATA_SIZE-1:0] out_dq_q, out_dq_d;

  logic [SW-1:0] sym_buf_q [2][FFT_SIZE];
  logic [SW-1:0] tbl_q [16];

  logic       in_fire, wr_last, adv;
  logic [1:0] full_eff;

  logic             issue, use_buf, start_sym, drain, nxt_full, next_sel, rd_bsel;
  logic [AddrW-1:0] rd_addr;
  logic [SW-1:0]    sample, buf_word;

  assign in_fire  = i_en && i_valid && o_ready;
  assign wr_last  = in_fire && (wr_cnt_q == AddrLastC);
  // A buffer completing this cycle counts as full so the reader can start on it immediately.
  assign full_eff = full_q | (wr_last ? (2'b01 << wr_sel_q) : 2'b00);
  assign adv      = i_en && (!out_valid_q || i_ready);

`ifdef OFDM_FRAME_GEN_PINGPONG_EN
  assign o_ready = (state_q == StLoad) ||
                   ((state_q inside {StPreA, StCp, StBody}) && (load_left_q != 8'd0) &&
                    !full_q[wr_sel_q]);
`else
  assign o_ready = (state_q == StLoad);
`endif

  assign o_valid      = out_valid_q;
  assign o_data_i     = out_di_q;
  assign o_data_q     = out_dq_q;
  assign o_busy       = (state_q != StIdle);
  assign o_frame_done = (state_q == StDone);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sym_left_d  = sym_left_q;
    load_left_d = load_left_q;
    wr_cnt_d    = wr_cnt_q;
    wr_sel_d    = wr_sel_q;
    rd_sel_d    = rd_sel_q;
    full_d      = full_q;
    out_valid_d = out_valid_q;
    out_di_d    = out_di_q;
    out_dq_d    = out_dq_q;
    issue       = 1'b0;
    use_buf     = 1'b0;
    start_sym   = 1'b0;
    drain       = 1'b0;
    nxt_full    = 1'b0;
    next_sel    = rd_sel_q;
    rd_bsel     = rd_sel_q;
    rd_addr     = '0;
    sample      = '0;
    buf_word    = '0;

    if (in_fire) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
      if (wr_last) begin
        wr_cnt_d         = '0;
        full_d[wr_sel_q] = 1'b1;
        load_left_d      = load_left_q - 8'd1;
`ifdef OFDM_FRAME_GEN_PINGPONG_EN
        wr_sel_d         = ~wr_sel_q;
`endif
      end
    end

    unique case (state_q)
      StIdle: begin
        if (i_en && i_start) begin
          state_d     = StPreA;
          cnt_d       = '0;
          sym_left_d  = i_num_sym;
          load_left_d = i_num_sym;
          wr_cnt_d    = '0;
          wr_sel_d    = 1'b0;
          rd_sel_d    = 1'b0;
          full_d      = '0;
        end
      end
      StPreA: begin
        if (adv) begin
          if (cnt_q < PreLenC) begin
            issue  = 1'b1;
            sample = tbl_q[cnt_q[3:0]];
            cnt_d  = cnt_q + 1'b1;
          end else begin
            drain    = 1'b1;
            nxt_full = full_eff[rd_sel_q];
          end
        end
      end
      StLoad: begin
        if (adv && full_eff[rd_sel_q]) start_sym = 1'b1;
      end
      StCp: begin
        if (adv) begin
          issue   = 1'b1;
          use_buf = 1'b1;
          rd_addr = CpBaseC + cnt_q[AddrW-1:0];
          if (cnt_q == CpLastC) begin
            state_d = StBody;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StBody: begin
        if (adv) begin
          if (cnt_q < FftC) begin
            issue   = 1'b1;
            use_buf = 1'b1;
            rd_addr = cnt_q[AddrW-1:0];
            cnt_d   = cnt_q + 1'b1;
          end else begin
            drain            = 1'b1;
            sym_left_d       = sym_left_q - 8'd1;
            full_d[rd_sel_q] = 1'b0;
`ifdef OFDM_FRAME_GEN_PINGPONG_EN
            rd_sel_d = ~rd_sel_q;
            next_sel = ~rd_sel_q;
            nxt_full = full_eff[~rd_sel_q];
`endif
          end
        end
      end
      StDone: begin
        if (i_en) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Output register has drained the last sample of the current section.
    if (drain) begin
      cnt_d = '0;
      if (sym_left_d == 8'd0) begin
        state_d = StDone;
      end else if (nxt_full) begin
        start_sym = 1'b1;
      end else begin
        state_d = StLoad;
      end
    end

    if (start_sym) begin
      issue   = 1'b1;
      use_buf = 1'b1;
      rd_bsel = next_sel;
      rd_addr = CpBaseC;
      if (CP_LEN == 1) begin
        state_d = StBody;
        cnt_d   = '0;
      end else begin
        state_d = StCp;
        cnt_d   = CntW'(1);
      end
    end

    // Bypass the sample being written this cycle so a just-completed buffer reads correctly.
    buf_word = sym_buf_q[rd_bsel][rd_addr];
    if (in_fire && (wr_sel_q == rd_bsel) && (wr_cnt_q == rd_addr)) begin
      buf_word = {in_data_i, in_data_q};
    end
    if (use_buf) sample = buf_word;

    if (adv) begin
      out_valid_d = issue;
      if (issue) {out_di_d, out_dq_d} = sample;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      sym_left_q  <= '0;
      load_left_q <= '0;
      wr_cnt_q    <= '0;
      wr_sel_q    <= 1'b0;
      rd_sel_q    <= 1'b0;
      full_q      <= '0;
      out_valid_q <= 1'b0;
      out_di_q    <= '0;
      out_dq_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sym_left_q  <= sym_left_d;
      load_left_q <= load_left_d;
      wr_cnt_q    <= wr_cnt_d;
      wr_sel_q    <= wr_sel_d;
      rd_sel_q    <= rd_sel_d;
      full_q      <= full_d;
      out_valid_q <= out_valid_d;
      out_di_q    <= out_di_d;
      out_dq_q    <= out_dq_d;
    end
  end

  // Storage arrays are deliberately not reset; the preamble table survives reset.
  always_ff @(posedge i_clk) begin
    if (in_fire) sym_buf_q[wr_sel_q][wr_cnt_q] <= {in_data_i, in_data_q};
    if (i_en && i_cfg_we && (state_q == StIdle)) begin
      tbl_q[i_cfg_addr] <= {i_cfg_data_i, i_cfg_data_q};
    end
  end

endmodule
